// File: rtl/vpu_cmd_dispatch.sv
// VPU command dispatcher: captures a command on start, streams header and payload
// words over a valid/ready bus, then waits for core completion (or timeout).
module vpu_cmd_dispatch #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [3:0]        code,
  input  logic [4:0]        obj_num,
  input  logic [1:0]        obj_type,
  input  logic [2:0]        obj_color,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] v1,
  input  logic [DATA_W-1:0] v2,
  input  logic [DATA_W-1:0] v3,
  input  logic [DATA_W-1:0] v4,
  input  logic [DATA_W-1:0] v5,
  input  logic [DATA_W-1:0] v6,
  input  logic [DATA_W-1:0] v7,
  input  logic [DATA_W-1:0] ro,
  output logic              vpu_rdy,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  input  logic              wr_ready,
  input  logic              vpu_done,
  input  logic [DATA_W-1:0] vpu_done_data,
  output logic [DATA_W-1:0] obj_data,
  output logic              obj_data_valid,
  output logic              busy_err,
  output logic              timeout_err,
  input  logic              clr_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Payload word count for a given op / object type.
  function automatic logic [3:0] pay_len(input logic [3:0] f_op, input logic [1:0] f_type);
    logic [3:0] len;
    case (f_op)
      4'h0: begin
        case (f_type)
          2'd0:    len = 4'd2;
          2'd1:    len = 4'd3;
          2'd2:    len = 4'd4;
          default: len = 4'd8;
        endcase
      end
      4'h3, 4'h4: len = 4'd1;
      4'hB, 4'hC: len = 4'd8;
      default:    len = 4'd0;
    endcase
    return len;
  endfunction

  logic [1:0]        r_state;
  logic [2:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic [3:0]        r_code;
  logic [4:0]        r_num;
  logic [1:0]        r_type;
  logic [2:0]        r_color;
  logic [DATA_W-1:0] r_v [8];
  logic [DATA_W-1:0] r_ro;
  logic              r_rdy;
  logic              r_wr_valid;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_last;
  logic [DATA_W-1:0] r_obj_data;
  logic              r_obj_valid;
  logic              r_busy_err;
  logic              r_tmo_err;

  logic              w_accept;
  logic [3:0]        w_c_op;
  logic [3:0]        w_c_code;
  logic [4:0]        w_c_num;
  logic [1:0]        w_c_type;
  logic [2:0]        w_c_color;
  logic [3:0]        w_cur_len;
  logic [3:0]        w_nxt_len;
  logic [1:0]        w_nxt_state;
  logic [2:0]        w_nxt_idx;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic              w_done_hit;
  logic              w_tmo_hit;
  logic [DATA_W-1:0] w_nxt_data;
  logic              w_nxt_last;
  logic [DATA_W-1:0] w_vin [8];

  assign w_vin[0] = v0;
  assign w_vin[1] = v1;
  assign w_vin[2] = v2;
  assign w_vin[3] = v3;
  assign w_vin[4] = v4;
  assign w_vin[5] = v5;
  assign w_vin[6] = v6;
  assign w_vin[7] = v7;

  // Header fields as they will be held after this edge, so the header can be registered on accept.
  assign w_accept  = start && (r_state == S_IDLE);
  assign w_c_op    = w_accept ? op        : r_op;
  assign w_c_code  = w_accept ? code      : r_code;
  assign w_c_num   = w_accept ? obj_num   : r_num;
  assign w_c_type  = w_accept ? obj_type  : r_type;
  assign w_c_color = w_accept ? obj_color : r_color;
  assign w_cur_len = pay_len(r_op, r_type);
  assign w_nxt_len = pay_len(w_c_op, w_c_type);

  // Next-state, payload index and WAIT_DONE counter.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_done_hit  = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_HDR;
          w_nxt_idx   = 3'd0;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_HDR: begin
        if (wr_ready) begin
          w_nxt_idx   = 3'd0;
          w_nxt_cnt   = '0;
          w_nxt_state = (w_cur_len == 4'd0) ? S_WAIT : S_PAY;
        end else begin
          w_nxt_state = S_HDR;
        end
      end
      S_PAY: begin
        if (wr_ready && ({1'b0, r_idx} == (w_cur_len - 4'd1))) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = '0;
        end else if (wr_ready) begin
          w_nxt_idx = r_idx + 3'd1;
        end else begin
          w_nxt_state = S_PAY;
        end
      end
      S_WAIT: begin
        // Completion on the final allowed cycle still counts as success.
        if (vpu_done) begin
          w_nxt_state = S_IDLE;
          w_done_hit  = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = S_IDLE;
          w_tmo_hit   = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Stream word and last flag for the upcoming cycle; unchanged while stalled.
  always_comb begin
    w_nxt_data = '0;
    w_nxt_last = 1'b0;
    case (w_nxt_state)
      S_HDR: begin
        w_nxt_data = DATA_W'({w_c_op, w_c_code, w_c_num, w_c_color});
        w_nxt_last = (w_nxt_len == 4'd0);
      end
      S_PAY: begin
        w_nxt_data = ((r_op == 4'h3) || (r_op == 4'h4)) ? r_ro : r_v[w_nxt_idx];
        w_nxt_last = ({1'b0, w_nxt_idx} == (w_cur_len - 4'd1));
      end
      default: begin
        w_nxt_data = '0;
        w_nxt_last = 1'b0;
      end
    endcase
  end

  // FSM, command capture and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= '0;
      r_op       <= 4'd0;
      r_code     <= 4'd0;
      r_num      <= 5'd0;
      r_type     <= 2'd0;
      r_color    <= 3'd0;
      r_ro       <= '0;
      for (int i = 0; i < 8; i++) r_v[i] <= '0;
      r_rdy      <= 1'b1;
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_wr_last  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_cnt      <= w_nxt_cnt;
      r_op       <= w_c_op;
      r_code     <= w_c_code;
      r_num      <= w_c_num;
      r_type     <= w_c_type;
      r_color    <= w_c_color;
      if (w_accept) begin
        r_ro <= ro;
        for (int i = 0; i < 8; i++) r_v[i] <= w_vin[i];
      end else begin
        r_ro <= r_ro;
      end
      r_rdy      <= (w_nxt_state == S_IDLE);
      r_wr_valid <= (w_nxt_state == S_HDR) || (w_nxt_state == S_PAY);
      r_wr_data  <= w_nxt_data;
      r_wr_last  <= w_nxt_last;
    end
  end

  // GETOBJ result capture and sticky errors; a set event beats clr_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_obj_data  <= '0;
      r_obj_valid <= 1'b0;
      r_busy_err  <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      if (w_done_hit && (r_op == 4'hF)) begin
        r_obj_data  <= vpu_done_data;
        r_obj_valid <= 1'b1;
      end else begin
        r_obj_valid <= 1'b0;
      end
      if (start && (r_state != S_IDLE)) begin
        r_busy_err <= 1'b1;
      end else if (clr_err) begin
        r_busy_err <= 1'b0;
      end else begin
        r_busy_err <= r_busy_err;
      end
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end else if (clr_err) begin
        r_tmo_err <= 1'b0;
      end else begin
        r_tmo_err <= r_tmo_err;
      end
    end
  end

  assign vpu_rdy        = r_rdy;
  assign wr_valid       = r_wr_valid;
  assign wr_data        = r_wr_data;
  assign wr_last        = r_wr_last;
  assign obj_data       = r_obj_data;
  assign obj_data_valid = r_obj_valid;
  assign busy_err       = r_busy_err;
  assign timeout_err    = r_tmo_err;

endmodule

// File: tb/tb_vpu_cmd_dispatch.sv
// Self-checking bench for vpu_cmd_dispatch: directed scenarios plus randomized
// commands, compared against a queue-based reference of the expected word stream.
module tb_vpu_cmd_dispatch;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_ready, vpu_done, clr_err;
  logic [3:0]  op, code;
  logic [4:0]  obj_num;
  logic [1:0]  obj_type;
  logic [2:0]  obj_color;
  logic [15:0] v [8];
  logic [15:0] ro, vpu_done_data;
  logic        vpu_rdy, wr_valid, wr_last, obj_data_valid, busy_err, timeout_err;
  logic [15:0] wr_data, obj_data;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [16:0] got_q [$];
  logic [16:0] exp_q [$];
  logic [15:0] exp_obj;

  always #5 clk = ~clk;

  vpu_cmd_dispatch #(.DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .code(code),
    .obj_num(obj_num), .obj_type(obj_type), .obj_color(obj_color),
    .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
    .v4(v[4]), .v5(v[5]), .v6(v[6]), .v7(v[7]), .ro(ro),
    .vpu_rdy(vpu_rdy), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .vpu_done(vpu_done), .vpu_done_data(vpu_done_data),
    .obj_data(obj_data), .obj_data_valid(obj_data_valid),
    .busy_err(busy_err), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: record any transfer, advance, then enforce the stall-hold rule.
  task automatic tick();
    logic        stalled;
    logic [16:0] held;
    stalled = wr_valid && !wr_ready && rst_n;
    held    = {wr_last, wr_data};
    if (wr_valid && wr_ready) got_q.push_back({wr_last, wr_data});
    @(posedge clk);
    #1;
    if (stalled) begin
      chk("hold_valid", {31'd0, wr_valid}, 32'd1);
      chk("hold_word", {15'd0, wr_last, wr_data}, {15'd0, held});
    end
  endtask

  function automatic int plen(input logic [3:0] o, input logic [1:0] t);
    if (o == 4'h0) return (t == 2'd0) ? 2 : (t == 2'd1) ? 3 : (t == 2'd2) ? 4 : 8;
    if (o == 4'h3 || o == 4'h4) return 1;
    if (o == 4'hB || o == 4'hC) return 8;
    return 0;
  endfunction

  task automatic build_exp(input logic [3:0] o, input logic [3:0] c, input logic [4:0] n,
                           input logic [1:0] t, input logic [2:0] col, input logic [15:0] r);
    int len;
    len = plen(o, t);
    exp_q.delete();
    exp_q.push_back({(len == 0), o, c, n, col});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), ((o == 4'h3 || o == 4'h4) ? r : v[i])});
  endtask

  task automatic scramble();
    op = 4'($urandom); code = 4'($urandom); obj_num = 5'($urandom);
    obj_type = 2'($urandom); obj_color = 3'($urandom); ro = 16'($urandom);
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
  endtask

  // Issue one command, collect its stream, then complete it after done_dly WAIT cycles.
  task automatic run_cmd(input logic [3:0] o, input logic [3:0] c, input logic [4:0] n,
                         input logic [1:0] t, input logic [2:0] col, input logic [15:0] r,
                         input int ready_pct, input int stall0, input int busy_at,
                         input int done_dly, input logic [15:0] ddata);
    int cyc;
    build_exp(o, c, n, t, col, r);
    got_q.delete();
    op = o; code = c; obj_num = n; obj_type = t; obj_color = col; ro = r;
    start = 1'b1;
    wr_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("start_valid", {31'd0, wr_valid}, 32'd1);
    chk("start_rdy", {31'd0, vpu_rdy}, 32'd0);
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 500) begin
      scramble();
      start = (cyc == busy_at);
      wr_ready = (cyc < stall0) ? 1'b0 : ($urandom_range(99) < ready_pct);
      tick();
      start = 1'b0;
      cyc++;
    end
    wr_ready = 1'b0;
    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("word%0d", i), {15'd0, got_q[i]}, {15'd0, exp_q[i]});
    chk("post_valid", {31'd0, wr_valid}, 32'd0);
    if (busy_at >= 0) chk("busy_set", {31'd0, busy_err}, 32'd1);
    repeat (done_dly) tick();
    chk("wait_rdy", {31'd0, vpu_rdy}, 32'd0);
    vpu_done = 1'b1;
    vpu_done_data = ddata;
    tick();
    vpu_done = 1'b0;
    if (o == 4'hF) exp_obj = ddata;
    chk("done_rdy", {31'd0, vpu_rdy}, 32'd1);
    chk("odv_pulse", {31'd0, obj_data_valid}, {31'd0, (o == 4'hF)});
    chk("obj_data", {16'd0, obj_data}, {16'd0, exp_obj});
    tick();
    chk("odv_clear", {31'd0, obj_data_valid}, 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0; vpu_done = 1'b0; clr_err = 1'b0;
    vpu_done_data = 16'h0; exp_obj = 16'h0;
    scramble();
    tick();
    tick();
    chk("rst_rdy", {31'd0, vpu_rdy}, 32'd1);
    chk("rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_data", {16'd0, wr_data}, 32'd0);
    chk("rst_last", {31'd0, wr_last}, 32'd0);
    chk("rst_obj", {16'd0, obj_data}, 32'd0);
    chk("rst_errs", {29'd0, obj_data_valid, busy_err, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // DRAW with three vertices, no backpressure.
    v[0] = 16'h0102; v[1] = 16'h0304; v[2] = 16'h0506;
    run_cmd(4'h0, 4'h0, 5'd3, 2'd1, 3'd5, 16'h0, 100, 0, -1, 3, 16'h0);
    // TRAN with the header stalled for three cycles.
    run_cmd(4'h3, 4'h0, 5'd1, 2'd0, 3'd1, 16'hBEEF, 100, 3, -1, 2, 16'h0);
    // GETOBJ result return.
    run_cmd(4'hF, 4'h2, 5'd7, 2'd0, 3'd2, 16'h0, 100, 0, -1, 1, 16'h1234);

    // Completion outside WAIT_DONE must be ignored.
    vpu_done = 1'b1; vpu_done_data = 16'hDEAD;
    tick();
    vpu_done = 1'b0;
    chk("idle_done_odv", {31'd0, obj_data_valid}, 32'd0);
    chk("idle_done_obj", {16'd0, obj_data}, {16'd0, exp_obj});
    chk("idle_done_rdy", {31'd0, vpu_rdy}, 32'd1);

    // Second start during payload streaming.
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    run_cmd(4'hB, 4'h1, 5'd9, 2'd0, 3'd3, 16'h0, 100, 0, 2, 0, 16'h0);
    pulse_clr();
    chk("busy_clr", {31'd0, busy_err}, 32'd0);

    // Set and clear in the same cycle: set wins.
    op = 4'h5; start = 1'b1; tick(); start = 1'b0;
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    start = 1'b1; clr_err = 1'b1; tick(); start = 1'b0; clr_err = 1'b0;
    chk("busy_set_wins", {31'd0, busy_err}, 32'd1);
    vpu_done = 1'b1; tick(); vpu_done = 1'b0;
    chk("busy_done_rdy", {31'd0, vpu_rdy}, 32'd1);
    pulse_clr();
    chk("busy_clr2", {31'd0, busy_err}, 32'd0);

    // Completion on the last allowed WAIT cycle wins over timeout.
    run_cmd(4'hF, 4'h0, 5'd2, 2'd0, 3'd0, 16'h0, 100, 0, -1, TMO - 1, 16'h5A5A);
    chk("edge_no_tmo", {31'd0, timeout_err}, 32'd0);

    // Timeout with no completion.
    op = 4'h5; start = 1'b1; tick(); start = 1'b0;
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    n = 0;
    while (!vpu_rdy && n < TMO + 50) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_odv", {31'd0, obj_data_valid}, 32'd0);
    chk("tmo_obj", {16'd0, obj_data}, {16'd0, exp_obj});
    pulse_clr();
    chk("tmo_clr", {31'd0, timeout_err}, 32'd0);

    // Reset while streaming the second word of a MAT command.
    op = 4'hB; start = 1'b1; wr_ready = 1'b1; tick(); start = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    wr_ready = 1'b0;
    chk("mrst_valid", {31'd0, wr_valid}, 32'd0);
    chk("mrst_rdy", {31'd0, vpu_rdy}, 32'd1);
    chk("mrst_obj", {16'd0, obj_data}, 32'd0);
    exp_obj = 16'h0;
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    run_cmd(4'hB, 4'h4, 5'd17, 2'd2, 3'd6, 16'h0, 100, 0, -1, 0, 16'h0);

    // Randomized commands with random backpressure and completion delay.
    for (int k = 0; k < 40; k++) begin
      logic [3:0]  ro_op;
      logic [15:0] rr;
      ro_op = 4'($urandom);
      rr = 16'($urandom);
      for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
      run_cmd(ro_op, 4'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), rr,
              $urandom_range(100, 30), $urandom_range(2), ($urandom_range(3) == 0) ? 0 : -1,
              $urandom_range(15), 16'($urandom));
      pulse_clr();
      chk("rand_clr", {30'd0, busy_err, timeout_err}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
